// File: rtl/decoder_nto2n_seq_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg: shared FSM state type and one-hot helper for decoder_nto2n_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package decoder_pkg;

  localparam int MAX_N = 8;
  localparam int MAX_W = 1 << MAX_N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Codes outside the 2^n range decode to all-zero rather than aliasing.
  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] code,
                                               input int unsigned n);
    logic [MAX_W-1:0] r;
    r = '0;
    if ({24'd0, code} < (32'd1 << n)) r[code] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_nto2n_seq_if.sv
// ----------------------------------------------------------------------------
// decoder_nto2n_seq_if: code handshake and decoded-output bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface decoder_nto2n_seq_if #(
  parameter int N = 4
) ();

  logic             en;
  logic             mode;
  logic [N-1:0]     i;
  logic             in_valid;
  logic             in_ready;
  logic [2**N-1:0]  d;
  logic             d_valid;
  logic             scan_wrap;

  modport master (
    output en, mode, i, in_valid,
    input  in_ready, d, d_valid, scan_wrap
  );

  modport slave (
    input  en, mode, i, in_valid,
    output in_ready, d, d_valid, scan_wrap
  );

endinterface

`default_nettype wire

// File: rtl/decoder_nto2n_seq_dwell_timer.sv
// ----------------------------------------------------------------------------
// dwell_timer: 8-bit up/down counter with load, clear and terminal count
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dwell_timer (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       clr_i,
  input  wire logic       load_i,
  input  wire logic [7:0] load_val_i,
  input  wire logic       cnt_en_i,
  input  wire logic       down_i,
  input  wire logic [7:0] term_i,
  output logic            tc_o
);

  logic [7:0] count_q, count_d;

  // Terminal count is term_i when counting up and zero when counting down.
  assign tc_o = down_i ? (count_q == 8'd0) : (count_q == term_i);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (cnt_en_i) begin
      if (tc_o) count_d = down_i ? term_i : 8'd0;
      else      count_d = down_i ? (count_q - 8'd1) : (count_q + 8'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 8'd0;
    else        count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/decoder_nto2n_seq.sv
// ----------------------------------------------------------------------------
// decoder_nto2n_seq: registered N-to-2^N one-hot decoder, direct and scan modes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decoder_nto2n_seq #(
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  decoder_nto2n_seq_if.slave   bus_if
);

  import decoder_pkg::*;

  localparam int         W    = 1 << N;
  localparam logic [7:0] TERM = 8'(DWELL - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   d_q, d_d;
  logic           d_valid_q, d_valid_d;
  logic           wrap_q, wrap_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           w_accept;
  logic           w_scan_run;
  logic           w_tc;

  assign bus_if.in_ready  = (state_q == DIRECT) && bus_if.en;
  assign bus_if.d         = d_q;
  assign bus_if.d_valid   = d_valid_q;
  assign bus_if.scan_wrap = wrap_q;

  assign w_accept   = bus_if.in_ready && bus_if.in_valid;
  assign w_scan_run = (state_q == SCAN) && bus_if.en && bus_if.mode;

  dwell_timer u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (!w_scan_run),
    .load_i     (1'b0),
    .load_val_i (8'd0),
    .cnt_en_i   (w_scan_run),
    .down_i     (1'b0),
    .term_i     (TERM),
    .tc_o       (w_tc)
  );

  // d trails cnt by one cycle, so the wrap pulse fires when d still shows the
  // top code while cnt has already rolled over to zero.
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    d_valid_d = d_valid_q;
    wrap_d    = 1'b0;
    cnt_d     = '0;
    if (!bus_if.en) begin
      state_d   = IDLE;
      d_d       = '0;
      d_valid_d = 1'b0;
    end else if (state_q == SCAN && bus_if.mode) begin
      d_d       = W'(onehot(8'(cnt_q), N));
      d_valid_d = 1'b1;
      wrap_d    = d_q[W-1] && (cnt_q == '0);
      cnt_d     = w_tc ? (cnt_q + N'(1)) : cnt_q;
    end else if (state_q == DIRECT && !bus_if.mode) begin
      if (w_accept) begin
        d_d       = W'(onehot(8'(bus_if.i), N));
        d_valid_d = 1'b1;
      end
    end else begin
      // Entry from IDLE or a mode change: start from a cleared output.
      state_d   = bus_if.mode ? SCAN : DIRECT;
      d_d       = '0;
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      wrap_q    <= wrap_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decoder_nto2n_seq.sv
// ----------------------------------------------------------------------------
// tb_decoder_nto2n_seq: time-based reference model plus directed/random stimulus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decoder_nto2n_seq;

  localparam int N     = 4;
  localparam int DWELL = 3;
  localparam int W     = 1 << N;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decoder_nto2n_seq_if #(.N(N)) bus_if ();

  decoder_nto2n_seq #(.N(N), .DWELL(DWELL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 direct, 2 scan. In scan, m_t counts edges since entry;
  // the code shown after edge k is (k-1)/DWELL mod 2^N.
  int         m_st;
  int         m_t;
  logic [W-1:0] m_d;
  logic       m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_t <= 0; m_d <= '0; m_wrap <= 1'b0;
    end else if (!bus_if.en) begin
      m_st <= 0; m_d <= '0; m_wrap <= 1'b0;
    end else if (m_st == 0 || (m_st == 1 && bus_if.mode) || (m_st == 2 && !bus_if.mode)) begin
      m_st <= bus_if.mode ? 2 : 1; m_t <= 0; m_d <= '0; m_wrap <= 1'b0;
    end else if (m_st == 1) begin
      m_wrap <= 1'b0;
      if (bus_if.in_valid) m_d <= W'(1) << bus_if.i;
    end else begin
      m_t    <= m_t + 1;
      m_d    <= W'(1) << ((m_t / DWELL) % W);
      m_wrap <= (m_t > 0) && (m_t % (W * DWELL) == 0);
    end
  end

  always @(negedge clk) begin
    chk("d", bus_if.d, m_d);
    chk("d_valid", bus_if.d_valid, m_d != '0);
    chk("scan_wrap", bus_if.scan_wrap, m_wrap);
    chk("in_ready", bus_if.in_ready, (m_st == 1) && bus_if.en);
    chk("popcount", ($countones(bus_if.d) <= 1), 1'b1);
    chk("valid_iff_onehot", bus_if.d_valid, ($countones(bus_if.d) == 1));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wraps;
    rst_n = 1'b0;
    bus_if.en = 1'b0; bus_if.mode = 1'b0; bus_if.i = '0; bus_if.in_valid = 1'b0;
    tick(2);
    chk("rst_d", bus_if.d, 16'h0000);
    chk("rst_d_valid", bus_if.d_valid, 1'b0);
    chk("rst_in_ready", bus_if.in_ready, 1'b0);
    chk("rst_wrap", bus_if.scan_wrap, 1'b0);
    rst_n = 1'b1;

    // Direct sweep of every code
    bus_if.en = 1'b1;
    tick(1);
    chk("direct_ready", bus_if.in_ready, 1'b1);
    for (int k = 0; k < W; k++) begin
      bus_if.i = N'(k); bus_if.in_valid = 1'b1;
      tick(1);
      chk("direct_sweep", bus_if.d, 16'h0001 << k);
    end

    // Hold without accepts
    bus_if.i = 4'hA;
    tick(1);
    bus_if.in_valid = 1'b0;
    repeat (5) begin
      bus_if.i = N'($urandom);
      tick(1);
    end
    chk("direct_hold", bus_if.d, 16'h0400);
    chk("direct_hold_valid", bus_if.d_valid, 1'b1);

    // Direct to scan switch
    bus_if.i = 4'h8; bus_if.in_valid = 1'b1;
    tick(1);
    chk("pre_switch", bus_if.d, 16'h0100);
    bus_if.in_valid = 1'b0; bus_if.mode = 1'b1;
    tick(1);
    chk("scan_entry_d", bus_if.d, 16'h0000);
    chk("scan_entry_ready", bus_if.in_ready, 1'b0);
    tick(1);
    chk("scan_first", bus_if.d, 16'h0001);

    // Two full sweeps: wrap pulses exactly twice, each with code 0 shown
    wraps = 0;
    repeat (97) begin
      tick(1);
      if (bus_if.scan_wrap) begin
        wraps++;
        chk("wrap_with_code0", bus_if.d, 16'h0001);
      end
    end
    chk("wrap_count", wraps, 2);

    // en drop at code 7 with a pending code
    bus_if.en = 1'b0;
    tick(2);
    bus_if.en = 1'b1;
    for (int c = 0; c < 200 && bus_if.d !== 16'h0080; c++) tick(1);
    chk("reach_code7", bus_if.d, 16'h0080);
    bus_if.en = 1'b0; bus_if.in_valid = 1'b1; bus_if.i = 4'h3;
    tick(1);
    chk("en_drop_d", bus_if.d, 16'h0000);
    chk("en_drop_valid", bus_if.d_valid, 1'b0);
    bus_if.in_valid = 1'b0; bus_if.en = 1'b1;
    tick(2);
    chk("rescan_code0", bus_if.d, 16'h0001);

    // Asynchronous reset between edges
    tick(4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_d", bus_if.d, 16'h0000);
    chk("async_rst_valid", bus_if.d_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_code0", bus_if.d, 16'h0001);

    // Random mode/en/code traffic checked by the model every cycle
    repeat (800) begin
      bus_if.en       = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) bus_if.mode = ~bus_if.mode;
      bus_if.i        = N'($urandom);
      bus_if.in_valid = 1'($urandom);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
